kb_matrix_scan: RTL and testbench

Parametrised matrix-keypad scanner: drives ROWS active-low row lines and senses COLS active-low column lines. It debounces press and release and encodes the held key as a linear code. Codes are queued in a small FIFO behind a valid/ready handshake, with optional auto-repeat while a key is held. It sits between the board I/O pins and any keycode consumer (display shifter, command decoder) and replaces the fixed 4×4 scan/debounce pair.

---
 rtl/kb_pkg.sv | 21 ++
 rtl/kb_fifo.sv | 54 +++++
 rtl/kb_matrix_scan.sv | 210 +++++++++++++++++++++
 tb/tb_kb_matrix_scan.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Shared definitions for the keypad matrix scanner.
//   scan_state_t : row state machine encoding
//   code_width() : width of a linear key code for a ROWS x COLS matrix
//   key_code_t   : key code type for the default 4x4 matrix
package kb_pkg;

   typedef enum logic [2:0] {
      ST_SCAN     = 3'd0,
      ST_DEBOUNCE = 3'd1,
      ST_HELD     = 3'd2,
      ST_MULTI    = 3'd3,
      ST_RELEASE  = 3'd4
   } scan_state_t;

   function automatic int code_width(input int rows, input int cols);
      return (rows * cols > 1) ? $clog2(rows * cols) : 1;
   endfunction

   typedef logic [3:0] key_code_t;

endpackage

// File: rtl/kb_fifo.sv
// First-word fall-through FIFO for key codes.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write data_i (dropped when full unless a pop happens in the same cycle)
//   pop_i     : consumer ready; a pop occurs only when the FIFO is non-empty
//   data_o    : head entry, reads 0 while empty
//   full_o, empty_o, count_o : occupancy status
module kb_fifo #(
   parameter int  DEPTH = 8,
   parameter int  WIDTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             wr_en, rd_en;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign rd_en   = pop_i & ~empty_o;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign wr_en   = push_i & (~full_o | rd_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/kb_matrix_scan.sv
// Matrix keypad scanner with debounce, linear key encoding, key-code FIFO
// and optional auto-repeat.
//   clk, rst   : clock, synchronous active-high reset
//   row_drive  : registered one-hot-low row strobe
//   col_sense  : raw active-low columns (asynchronous, pulled up)
//   key_code   : FIFO head, row*COLS+col
//   key_valid  : FIFO non-empty
//   key_ready  : consumer ready
//   key_held   : a single key is debounced-down
//   overflow   : sticky, a code was dropped on a full FIFO
//   fifo_count : entries queued
// Handshake: a code transfers on every rising edge where key_valid and
// key_ready are both 1; key_code/key_valid hold until that edge.
module kb_matrix_scan
   import kb_pkg::*;
#(
   parameter int  ROWS          = 4,
   parameter int  COLS          = 4,
   parameter int  SETTLE_CYC    = 4,
   parameter int  DB_CYC        = 65536,
   parameter int  REPEAT_EN     = 0,
   parameter int  REPEAT_DELAY  = 1 << 24,
   parameter int  REPEAT_PERIOD = 1 << 22,
   parameter int  FIFO_DEPTH    = 8,
   localparam int CODE_W        = code_width(ROWS, COLS),
   localparam int CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ROWS-1:0]   row_drive,
   input  logic [COLS-1:0]   col_sense,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              key_held,
   output logic              overflow,
   output logic [CNT_W-1:0]  fifo_count
);

   localparam int RW      = $clog2(ROWS);
   localparam int CW      = $clog2(COLS);
   localparam int SW      = $clog2(SETTLE_CYC + 2);
   localparam int DW      = $clog2(DB_CYC);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic [COLS-1:0]   sync1_q, cs_q;
   scan_state_t       state_q, state_d;
   logic [RW-1:0]     r_q, r_d, r_next;
   logic [SW-1:0]     set_q, set_d;
   logic [DW-1:0]     db_q, db_d;
   logic [COLS-1:0]   pat_q, pat_d;
   logic [REP_W-1:0]  rep_q, rep_d;
   logic              rep_first_q, rep_first_d;
   logic [ROWS-1:0]   row_drive_q;
   logic              overflow_q;
   logic              push, rep_hit;
   logic [CODE_W-1:0] push_code;
   logic [COLS-1:0]   lows;
   logic              single_low;
   logic [CW-1:0]     low_col;
   logic              fifo_full, fifo_empty;

   assign r_next     = (r_q == RW'(ROWS - 1)) ? '0 : r_q + 1'b1;
   assign lows       = ~pat_q;
   // Clearing the lowest set bit leaves zero only when exactly one column is low.
   assign single_low = (lows != '0) && ((lows & (lows - 1'b1)) == '0);
   assign rep_hit    = rep_first_q ? (rep_q == REP_W'(REPEAT_DELAY - 1))
                                   : (rep_q == REP_W'(REPEAT_PERIOD - 1));

   always_comb begin
      low_col = '0;
      for (int c = 0; c < COLS; c++) begin
         if (!pat_q[c]) low_col = CW'(c);
      end
   end

   assign push_code = CODE_W'(int'(r_q) * COLS + int'(low_col));

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      set_d       = set_q;
      db_d        = db_q;
      pat_d       = pat_q;
      rep_d       = rep_q;
      rep_first_d = rep_first_q;
      push        = 1'b0;
      case (state_q)
         ST_SCAN: begin
            // The extra two settle cycles cover the synchronizer delay.
            if (set_q == SW'(SETTLE_CYC + 1)) begin
               set_d = '0;
               if (&cs_q) begin
                  r_d = r_next;
               end else begin
                  pat_d   = cs_q;
                  db_d    = '0;
                  state_d = ST_DEBOUNCE;
               end
            end else begin
               set_d = set_q + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (cs_q != pat_q) begin
               state_d = ST_SCAN;
               set_d   = '0;
            end else if (db_q == DW'(DB_CYC - 1)) begin
               db_d = '0;
               if (single_low) begin
                  push        = 1'b1;
                  state_d     = ST_HELD;
                  rep_d       = '0;
                  rep_first_d = 1'b1;
               end else begin
                  state_d = ST_MULTI;
               end
            end else begin
               db_d = db_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (cs_q != pat_q) begin
               state_d = ST_RELEASE;
               db_d    = '0;
               rep_d   = '0;
            end else if (REPEAT_EN != 0) begin
               if (rep_hit) begin
                  push        = 1'b1;
                  rep_d       = '0;
                  rep_first_d = 1'b0;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
         end
         ST_MULTI: begin
            if (cs_q != pat_q) begin
               state_d = ST_RELEASE;
               db_d    = '0;
            end
         end
         ST_RELEASE: begin
            if (!(&cs_q)) begin
               db_d = '0;
            end else if (db_q == DW'(DB_CYC - 1)) begin
               db_d    = '0;
               state_d = ST_SCAN;
               set_d   = '0;
               r_d     = r_next;
            end else begin
               db_d = db_q + 1'b1;
            end
         end
         default: state_d = ST_SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= '1;
         cs_q        <= '1;
         state_q     <= ST_SCAN;
         r_q         <= '0;
         set_q       <= '0;
         db_q        <= '0;
         pat_q       <= '1;
         rep_q       <= '0;
         rep_first_q <= 1'b0;
         row_drive_q <= {{(ROWS-1){1'b1}}, 1'b0};
         overflow_q  <= 1'b0;
      end else begin
         sync1_q     <= col_sense;
         cs_q        <= sync1_q;
         state_q     <= state_d;
         r_q         <= r_d;
         set_q       <= set_d;
         db_q        <= db_d;
         pat_q       <= pat_d;
         rep_q       <= rep_d;
         rep_first_q <= rep_first_d;
         // Strobe follows the row index one cycle later.
         row_drive_q <= ~(ROWS'(1) << r_q);
         // A full FIFO has key_valid=1, so key_ready alone means a same-edge pop.
         overflow_q  <= overflow_q | (push & fifo_full & ~key_ready);
      end
   end

   kb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CODE_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (push_code),
      .pop_i   (key_ready),
      .data_o  (key_code),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign row_drive = row_drive_q;
   assign key_valid = ~fifo_empty;
   assign key_held  = (state_q == ST_HELD);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_kb_matrix_scan.sv
// Testbench for kb_matrix_scan: a keypad model drives the columns from the
// row strobe, a queue model tracks the expected FIFO contents, and a
// per-cycle compare process checks the DUT against it.
module tb_kb_matrix_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: no auto-repeat.
   logic        rst_a, key_ready_a, key_valid_a, key_held_a, overflow_a;
   logic [3:0]  row_drive_a, col_a, key_code_a;
   logic [2:0]  fifo_count_a;
   logic [15:0] keys_a;

   // Instance B: auto-repeat enabled.
   logic        rst_b, key_ready_b, key_valid_b, key_held_b, overflow_b;
   logic [3:0]  row_drive_b, col_b, key_code_b;
   logic [2:0]  fifo_count_b;
   logic [15:0] keys_b;

   kb_matrix_scan #(
      .ROWS(4), .COLS(4), .SETTLE_CYC(4), .DB_CYC(16), .REPEAT_EN(0),
      .REPEAT_DELAY(50), .REPEAT_PERIOD(20), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst_a), .row_drive(row_drive_a), .col_sense(col_a),
      .key_code(key_code_a), .key_valid(key_valid_a), .key_ready(key_ready_a),
      .key_held(key_held_a), .overflow(overflow_a), .fifo_count(fifo_count_a)
   );

   kb_matrix_scan #(
      .ROWS(4), .COLS(4), .SETTLE_CYC(4), .DB_CYC(16), .REPEAT_EN(1),
      .REPEAT_DELAY(50), .REPEAT_PERIOD(20), .FIFO_DEPTH(4)
   ) dut_rep (
      .clk(clk), .rst(rst_b), .row_drive(row_drive_b), .col_sense(col_b),
      .key_code(key_code_b), .key_valid(key_valid_b), .key_ready(key_ready_b),
      .key_held(key_held_b), .overflow(overflow_b), .fifo_count(fifo_count_b)
   );

   // Keypad: a pressed key at (r,c) pulls column c low while row r is strobed.
   always_comb begin
      col_a = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys_a[r*4+c] && !row_drive_a[r]) col_a[c] = 1'b0;
   end

   always_comb begin
      col_b = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys_b[r*4+c] && !row_drive_b[r]) col_b[c] = 1'b0;
   end

   // Scoreboard / model state.
   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] exp_q[$];
   logic       exp_held, exp_ovf, chk_en;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("fifo_count", int'(fifo_count_a), exp_q.size());
         check("key_valid", int'(key_valid_a), int'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("key_code", int'(key_code_a), int'(exp_q[0]));
         check("key_held", int'(key_held_a), int'(exp_held));
         check("overflow", int'(overflow_a), int'(exp_ovf));
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_a = 1'b0;
   endtask

   task automatic press_wait(input int code, input int cyc);
      chk_en = 1'b0;
      keys_a = 16'(1) << code;
      wait_cyc(cyc);
      if (exp_q.size() < 4) exp_q.push_back(4'(code));
      else exp_ovf = 1'b1;
      exp_held = 1'b1;
      chk_en   = 1'b1;
      wait_cyc(4);
   endtask

   task automatic release_wait(input int cyc);
      chk_en = 1'b0;
      keys_a = '0;
      wait_cyc(cyc);
      exp_held = 1'b0;
      chk_en   = 1'b1;
      wait_cyc(4);
   endtask

   task automatic pop_check(input string name, input int lit);
      @(negedge clk);
      check(name, int'(key_code_a), lit);
      key_ready_a = 1'b1;
      @(posedge clk);
      #1;
      key_ready_a = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   int         n, rd_n, nrise;
   logic [3:0] rd_v, seen;
   logic       prev;
   int         rise_t[4];
   int         exp_t[4] = '{50, 70, 90, 110};

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      keys_a = '0; keys_b = '0;
      key_ready_a = 1'b0; key_ready_b = 1'b1;
      chk_en = 1'b0; exp_held = 1'b0; exp_ovf = 1'b0;

      // Reset values and idle row rotation.
      reset_a();
      rst_b = 1'b0;
      check("rst_row_drive", int'(row_drive_a), 14);
      check("rst_valid", int'(key_valid_a), 0);
      check("rst_overflow", int'(overflow_a), 0);
      check("rst_count", int'(fifo_count_a), 0);
      check("rst_held", int'(key_held_a), 0);
      check("rst_code", int'(key_code_a), 0);
      for (int i = 1; i <= 25; i++) begin
         @(posedge clk);
         #1;
         case (i)
            6:  check("idle_row0_end", int'(row_drive_a), 14);
            7:  check("idle_row1", int'(row_drive_a), 13);
            12: check("idle_row1_end", int'(row_drive_a), 13);
            13: check("idle_row2", int'(row_drive_a), 11);
            19: check("idle_row3", int'(row_drive_a), 7);
            25: check("idle_wrap_row0", int'(row_drive_a), 14);
            default: ;
         endcase
      end

      // Press latency from reset: 2 sync + 4 settle + 16 debounce.
      keys_a = 16'h0001;
      reset_a();
      n = 0;
      while (!key_valid_a && n < 60) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("press_latency", n, 22);
      check("latency_code", int'(key_code_a), 0);
      exp_q.push_back(4'd0);
      exp_held = 1'b1;
      chk_en   = 1'b1;
      wait_cyc(5);
      release_wait(40);
      pop_check("pop_latency_code", 0);

      // Row 2 / col 1 held, then released with exact resume timing.
      press_wait(9, 100);
      keys_a = '0;
      rd_n = 0;
      rd_v = '0;
      for (int i = 1; i <= 24; i++) begin
         @(posedge clk);
         #1;
         if (i == 3) exp_held = 1'b0;
         if (i == 2) check("held_before_fall", int'(key_held_a), 1);
         if (i == 3) check("held_after_fall", int'(key_held_a), 0);
         if (rd_n == 0 && row_drive_a != 4'b1011) begin
            rd_n = i;
            rd_v = row_drive_a;
         end
      end
      check("resume_cycle", rd_n, 20);
      check("resume_row3", int'(rd_v), 7);
      pop_check("pop_code9", 9);

      // Bouncing col 0 on row 0: nothing may be queued while it bounces.
      keys_a = 16'h0001;
      for (int i = 0; i < 12; i++) begin
         wait_cyc(5);
         keys_a[0] = ~keys_a[0];
      end
      press_wait(0, 60);
      release_wait(40);
      pop_check("pop_bounce_code0", 0);

      // Two keys on row 1: MULTI, no push, key_held stays 0.
      keys_a = 16'h0090;
      wait_cyc(80);
      keys_a = '0;
      wait_cyc(40);
      seen = '0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         case (row_drive_a)
            4'b1110: seen[0] = 1'b1;
            4'b1101: seen[1] = 1'b1;
            4'b1011: seen[2] = 1'b1;
            4'b0111: seen[3] = 1'b1;
            default: ;
         endcase
      end
      check("multi_scan_resumes", int'(seen), 15);

      // Fill the FIFO with key_ready low.
      press_wait(1, 60);  release_wait(40);
      press_wait(7, 60);  release_wait(40);
      press_wait(12, 60); release_wait(40);
      press_wait(6, 60);
      check("fill_count", int'(fifo_count_a), 4);
      // Release key 6 (row 1) while pressing key 10 (row 2); pop on the push edge.
      keys_a = 16'(1) << 10;
      for (int i = 1; i <= 45; i++) begin
         @(posedge clk);
         #1;
         if (i == 3) exp_held = 1'b0;
         if (i == 40) key_ready_a = 1'b1;
         if (i == 41) begin
            key_ready_a = 1'b0;
            void'(exp_q.pop_front());
            exp_q.push_back(4'd10);
            exp_held = 1'b1;
            check("full_pushpop_count", int'(fifo_count_a), 4);
            check("full_pushpop_no_ovf", int'(overflow_a), 0);
         end
      end
      release_wait(40);
      press_wait(15, 60);
      check("drop_overflow", int'(overflow_a), 1);
      release_wait(40);
      pop_check("drain0", 7);
      pop_check("drain1", 12);
      pop_check("drain2", 6);
      pop_check("drain3", 10);
      wait_cyc(4);
      chk_en = 1'b0;

      // Auto-repeat on instance B, key 5.
      keys_b = 16'(1) << 5;
      n = 0;
      while (!key_valid_b && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rep_first_seen", int'(key_valid_b), 1);
      check("rep_first_code", int'(key_code_b), 5);
      nrise = 0;
      prev  = 1'b1;
      for (int k = 1; k <= 120; k++) begin
         @(posedge clk);
         #1;
         if (key_valid_b && !prev) begin
            if (nrise < 4) rise_t[nrise] = k;
            nrise++;
            check("rep_code", int'(key_code_b), 5);
         end
         prev = key_valid_b;
         if (k == 60) check("rep_held", int'(key_held_b), 1);
         if (k == 100) key_ready_b = 1'b0;
      end
      check("rep_push_count", nrise, 4);
      for (int i = 0; i < 4; i++) check($sformatf("rep_time%0d", i), rise_t[i], exp_t[i]);
      check("rep_pending", int'(fifo_count_b), 1);
      check("rep_no_overflow", int'(overflow_b), 0);

      // Reset in the middle of a held, repeating key.
      rst_b = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_count", int'(fifo_count_b), 0);
      check("midrst_valid", int'(key_valid_b), 0);
      check("midrst_held", int'(key_held_b), 0);
      check("midrst_row0", int'(row_drive_b), 14);
      check("midrst_code", int'(key_code_b), 0);
      rst_b = 1'b0;
      wait_cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
